// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller in front of an 8-byte-wide byte-addressed data memory
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 524288
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write_enable,
    output logic [31:0] mem_rw_addr,
    output logic [63:0] mem_rw_val,
    input  logic [63:0] mem_r_out
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_RMW_READ = 3'd2;
    localparam logic [2:0] S_WRITE    = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    // Highest start address whose full doubleword still lies inside memory.
    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 8);

    logic [2:0]  state_q,  state_d;
    logic [31:0] addr_q,   addr_d;
    logic [1:0]  size_q,   size_d;
    logic        signed_q, signed_d;
    logic        we_q,     we_d;
    logic [63:0] wdata_q,  wdata_d;
    logic [63:0] merge_q,  merge_d;
    logic [63:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] size,
                                           input logic sgn);
        logic [63:0] v;
        case (size)
            2'd0:    v = {{56{sgn & raw[7]}},  raw[7:0]};
            2'd1:    v = {{48{sgn & raw[15]}}, raw[15:0]};
            2'd2:    v = {{32{sgn & raw[31]}}, raw[31:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [1:0] size);
        logic [63:0] v;
        case (size)
            2'd0:    v = {old[63:8],  wd[7:0]};
            2'd1:    v = {old[63:16], wd[15:0]};
            2'd2:    v = {old[63:32], wd[31:0]};
            default: v = wd;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    if (req_addr > MAX_ADDR) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_size == 2'd3) begin
                        merge_d = req_wdata;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RMW_READ;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = extend(mem_r_out, size_q, signed_q);
                state_d = S_RESP;
            end
            S_RMW_READ: begin
                merge_d = merge(mem_r_out, wdata_q, size_q);
                state_d = S_WRITE;
            end
            S_WRITE:  state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Write enable is a pure state decode so an async reset cuts it off mid-cycle.
    assign req_ready        = (state_q == S_IDLE);
    assign resp_valid       = (state_q == S_RESP);
    assign resp_err         = resp_valid & err_q;
    assign resp_rdata       = we_q ? '0 : rdata_q;
    assign mem_write_enable = (state_q == S_WRITE);
    assign mem_rw_addr      = addr_q;
    assign mem_rw_val       = merge_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl with a byte-array memory and reference model
module tb_lsu_ctrl;

    localparam int unsigned MEM_BYTES = 524288;
    localparam logic [31:0] TOP = 32'(MEM_BYTES - 8);

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_write_enable;
    logic [31:0] mem_rw_addr;
    logic [63:0] mem_rw_val;
    logic [63:0] mem_r_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_write_enable(mem_write_enable),
        .mem_rw_addr(mem_rw_addr), .mem_rw_val(mem_rw_val), .mem_r_out(mem_r_out)
    );

    // Memory seen by the DUT, and the reference model's own copy.
    logic [7:0] dmem [MEM_BYTES];
    logic [7:0] rmem [MEM_BYTES];

    always_comb begin
        mem_r_out = '0;
        if (mem_rw_addr <= TOP)
            for (int i = 0; i < 8; i++) mem_r_out[8*i +: 8] = dmem[mem_rw_addr + 32'(i)];
    end

    always @(posedge clk)
        if (mem_write_enable && mem_rw_addr <= TOP)
            for (int i = 0; i < 8; i++) dmem[mem_rw_addr + 32'(i)] <= mem_rw_val[8*i +: 8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) begin
            dmem[a + 32'(i)] <= v[8*i +: 8];
            rmem[a + 32'(i)] = v[8*i +: 8];
        end
    endtask

    // Reference: sized byte access on a flat byte array.
    function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [63:0] wdata,
                                  output logic [63:0] rd, output logic err,
                                  output int lat, output int wcyc);
        int n = 1 << size;
        rd   = '0;
        wcyc = 0;
        err  = (addr > TOP);
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            for (int i = 0; i < n; i++) rd[8*i +: 8] = rmem[addr + 32'(i)];
            if (sgn && n < 8 && rd[8*n-1])
                for (int i = 8*n; i < 64; i++) rd[i] = 1'b1;
        end else begin
            lat  = (n == 8) ? 2 : 3;
            wcyc = lat - 1;
            for (int i = 0; i < n; i++) rmem[addr + 32'(i)] = wdata[8*i +: 8];
        end
    endfunction

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rd, output logic err, output int lat,
                          output int rcnt, output int wcnt, output int wcyc);
        @(negedge clk);
        chk("ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rd = '0; err = 1'b0; lat = -1; rcnt = 0; wcnt = 0; wcyc = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (mem_write_enable) begin wcnt++; wcyc = c; end
            if (resp_valid) begin
                rcnt++;
                if (lat < 0) begin lat = c; rd = resp_rdata; err = resp_err; end
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [63:0] wdata;
    } req_t;

    typedef struct {
        logic [63:0] rd;
        logic        err;
    } exp_t;

    vec_t tbl[10];

    initial begin
        logic [63:0] rd, erd;
        logic        err, eerr;
        int          lat, elat, rcnt, wcnt, wcyc, ewcyc;
        req_t        rq[$];
        exp_t        eq[$];
        exp_t        e;
        int          acc, rsp;
        logic        accept;

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < MEM_BYTES; i++) begin dmem[i] <= 8'h00; rmem[i] = 8'h00; end
        poke(32'h100, 64'h8877665544332211);
        poke(32'h200, 64'h1111111111111111);
        poke(32'h400, 64'h0102030405060708);
        for (int i = 0; i < 80; i += 8) poke(32'h1000 + 32'(i), {$urandom, $urandom});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err",   64'(resp_err), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_we",         64'(mem_write_enable), 64'd0);
        chk("rst_addr",       64'(mem_rw_addr), 64'd0);
        chk("rst_wval",       mem_rw_val, 64'd0);
        reset = 1'b1;

        tbl[0] = '{1'b0, 2'd0, 1'b1, 32'h107, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 2};
        tbl[1] = '{1'b0, 2'd2, 1'b0, 32'h104, 64'h0, 64'h0000000088776655, 1'b0, 2};
        tbl[2] = '{1'b0, 2'd2, 1'b1, 32'h104, 64'h0, 64'hFFFFFFFF88776655, 1'b0, 2};
        tbl[3] = '{1'b0, 2'd1, 1'b1, 32'h103, 64'h0, 64'h0000000000005544, 1'b0, 2};
        tbl[4] = '{1'b1, 2'd1, 1'b0, 32'h200, 64'hABCD, 64'h0, 1'b0, 3};
        tbl[5] = '{1'b0, 2'd3, 1'b0, 32'h200, 64'h0, 64'h111111111111ABCD, 1'b0, 2};
        tbl[6] = '{1'b1, 2'd3, 1'b0, TOP, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0, 2};
        tbl[7] = '{1'b1, 2'd3, 1'b0, TOP + 32'd1, 64'h0123456789ABCDEF, 64'h0, 1'b1, 1};
        tbl[8] = '{1'b0, 2'd0, 1'b0, 32'hFFFFFFF8, 64'h0, 64'h0, 1'b1, 1};
        tbl[9] = '{1'b0, 2'd3, 1'b0, TOP, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 2};

        for (int k = 0; k < 10; k++) begin
            model(tbl[k].we, tbl[k].size, tbl[k].sgn, tbl[k].addr, tbl[k].wdata,
                  erd, eerr, elat, ewcyc);
            do_req(tbl[k].we, tbl[k].size, tbl[k].sgn, tbl[k].addr, tbl[k].wdata,
                   rd, err, lat, rcnt, wcnt, wcyc);
            chk($sformatf("tbl%0d_rdata", k), rd, tbl[k].rd);
            chk($sformatf("tbl%0d_err", k), 64'(err), 64'(tbl[k].err));
            chk($sformatf("tbl%0d_lat", k), 64'(lat), 64'(tbl[k].lat));
            chk($sformatf("tbl%0d_rcnt", k), 64'(rcnt), 64'd1);
            chk($sformatf("tbl%0d_wcnt", k), 64'(wcnt),
                64'((tbl[k].we && !tbl[k].err) ? 1 : 0));
            if (tbl[k].we && !tbl[k].err)
                chk($sformatf("tbl%0d_wcyc", k), 64'(wcyc), 64'(tbl[k].lat - 1));
        end

        // Requests held back to back with req_valid high throughout.
        rq.push_back('{1'b0, 2'd3, 1'b0, 32'h100, 64'h0});
        rq.push_back('{1'b1, 2'd2, 1'b0, 32'h300, 64'h12345678});
        rq.push_back('{1'b0, 2'd3, 1'b0, 32'h300, 64'h0});
        rq.push_back('{1'b0, 2'd1, 1'b1, 32'hFFFFFFF8, 64'h0});
        acc = 0; rsp = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("b2b_ready", 64'(req_ready), 64'(eq.size() == 0));
            if (resp_valid) begin
                rsp++;
                if (eq.size() == 0) begin
                    chk("b2b_spurious_resp", 64'd1, 64'd0);
                end else begin
                    e = eq.pop_front();
                    chk("b2b_rdata", resp_rdata, e.rd);
                    chk("b2b_err", 64'(resp_err), 64'(e.err));
                end
            end
            if (rq.size() != 0) begin
                req_valid = 1'b1; req_we = rq[0].we; req_size = rq[0].size;
                req_signed = rq[0].sgn; req_addr = rq[0].addr; req_wdata = rq[0].wdata;
            end else begin
                req_valid = 1'b0;
            end
            accept = req_valid && req_ready;
            @(posedge clk);
            if (accept) begin
                model(rq[0].we, rq[0].size, rq[0].sgn, rq[0].addr, rq[0].wdata,
                      erd, eerr, elat, ewcyc);
                e.rd = erd; e.err = eerr;
                eq.push_back(e);
                void'(rq.pop_front());
                acc++;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 64'(acc), 64'd4);
        chk("b2b_resps", 64'(rsp), 64'd4);

        // Reset during the WRITE cycle of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h402; req_wdata = 64'hEE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstw_we_before", 64'(mem_write_enable), 64'd1);
        reset = 1'b0;
        #1;
        chk("rstw_we", 64'(mem_write_enable), 64'd0);
        chk("rstw_resp_valid", 64'(resp_valid), 64'd0);
        chk("rstw_rdata", resp_rdata, 64'd0);
        chk("rstw_err", 64'(resp_err), 64'd0);
        chk("rstw_addr", 64'(mem_rw_addr), 64'd0);
        chk("rstw_wval", mem_rw_val, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        rcnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid) rcnt++;
        end
        chk("rstw_no_resp", 64'(rcnt), 64'd0);
        model(1'b0, 2'd3, 1'b0, 32'h400, 64'h0, erd, eerr, elat, ewcyc);
        do_req(1'b0, 2'd3, 1'b0, 32'h400, 64'h0, rd, err, lat, rcnt, wcnt, wcyc);
        chk("rstw_load_rdata", rd, erd);
        chk("rstw_load_const", rd, 64'h0102030405060708);
        chk("rstw_load_lat", 64'(lat), 64'(elat));

        // Randomized requests against the model.
        for (int k = 0; k < 300; k++) begin
            logic        we, sgn;
            logic [1:0]  size;
            logic [31:0] addr;
            logic [63:0] wd;
            int          sel;
            we = 1'(($urandom & 1));
            sgn = 1'(($urandom & 1));
            size = 2'($urandom_range(0, 3));
            wd = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            if (sel == 0)      addr = $urandom;
            else if (sel == 1) addr = TOP - 32'd8 + 32'($urandom_range(0, 16));
            else               addr = 32'h1000 + 32'($urandom_range(0, 63));
            model(we, size, sgn, addr, wd, erd, eerr, elat, ewcyc);
            do_req(we, size, sgn, addr, wd, rd, err, lat, rcnt, wcnt, wcyc);
            chk($sformatf("rnd%0d_rdata", k), rd, erd);
            chk($sformatf("rnd%0d_err", k), 64'(err), 64'(eerr));
            chk($sformatf("rnd%0d_lat", k), 64'(lat), 64'(elat));
            chk($sformatf("rnd%0d_rcnt", k), 64'(rcnt), 64'd1);
            chk($sformatf("rnd%0d_wcnt", k), 64'(wcnt), 64'((ewcyc != 0) ? 1 : 0));
            chk($sformatf("rnd%0d_wcyc", k), 64'(wcyc), 64'(ewcyc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
